decoder_nivel_caixa: RTL and testbench

Recovers the tank water level from the seven segment lines driven by the level encoder. Applies a stability filter and flags persistent invalid patterns as a fault. Sits at the display end of the tank-level path, where it cross-checks what the display shows and provides a clean, registered level to supervisory logic.

---
 rtl/nivel_caixa_pkg.sv | 43 ++++
 rtl/segment_stability_filter.sv | 54 +++++
 rtl/decoder_nivel_caixa.sv | 123 ++++++++++++
 tb/tb_decoder_nivel_caixa.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nivel_caixa_pkg.sv
// Shared types and constants for the tank-level segment decoder.
package nivel_caixa_pkg;

  typedef enum logic [1:0] {
    LEVEL_EMPTY  = 2'd0,
    LEVEL_LOW    = 2'd1,
    LEVEL_MEDIUM = 2'd2,
    LEVEL_FULL   = 2'd3
  } levelCodeT;

  // Segment vector order is {segA,segB,segC,segD,segE,segF,segG}.
  localparam logic [6:0] SEG_FULL   = 7'h36;
  localparam logic [6:0] SEG_MEDIUM = 7'h76;
  localparam logic [6:0] SEG_LOW    = 7'h37;
  localparam logic [6:0] SEG_EMPTY  = 7'h31;

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    LOCKED  = 2'd1,
    FAULT   = 2'd2
  } stateT;

  typedef struct packed {
    logic       valid;
    logic [1:0] code;
  } decodeT;

  // Map a segment pattern to its level code; anything not in the table is invalid.
  function automatic decodeT decodePattern(input logic [6:0] pattern);
    decodeT d;
    d.valid = 1'b1;
    d.code  = LEVEL_EMPTY;
    case (pattern)
      SEG_FULL:   d.code = LEVEL_FULL;
      SEG_MEDIUM: d.code = LEVEL_MEDIUM;
      SEG_LOW:    d.code = LEVEL_LOW;
      SEG_EMPTY:  d.code = LEVEL_EMPTY;
      default:    d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/segment_stability_filter.sv
// Registers the segment vector and counts how long it has been unchanged.
// stableHit pulses once per run, on the edge the run length reaches
// STABLE_CYCLES; stableSample is the registered sample that run refers to.
module segment_stability_filter
  import nivel_caixa_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic [6:0] segments,
  output logic [6:0] stableSample,
  output logic       stableHit
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(STABLE_CYCLES);

  logic [6:0]    sampleReg;
  logic [CW-1:0] stableCount;
  logic [CW-1:0] countNext;
  logic          hitNext;

  assign stableSample = sampleReg;

  // Next run length: restart on change, saturate at the threshold, zero on clear.
  always_comb begin
    countNext = stableCount;
    if (clear) begin
      countNext = '0;
    end else if (segments != sampleReg) begin
      countNext = CW'(1);
    end else if (stableCount != STABLE_MAX) begin
      countNext = stableCount + 1'b1;
    end
    hitNext = !clear && (countNext == STABLE_MAX) &&
              ((stableCount != STABLE_MAX) || (segments != sampleReg));
  end

  // Sample register, run counter and the one-shot hit flag.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sampleReg   <= 7'h00;
      stableCount <= '0;
      stableHit   <= 1'b0;
    end else begin
      sampleReg   <= segments;
      stableCount <= countNext;
      stableHit   <= hitNext;
    end
  end

endmodule

// File: rtl/decoder_nivel_caixa.sv
// Recovers the tank level from the seven segment lines, filters it for
// stability and trips a fault on persistently invalid patterns.
module decoder_nivel_caixa
  import nivel_caixa_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int FAULT_CYCLES  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       segA,
  input  logic       segB,
  input  logic       segC,
  input  logic       segD,
  input  logic       segE,
  input  logic       segF,
  input  logic       segG,
  input  logic       faultClear,
  output logic       highLevel,
  output logic       mediumLevel,
  output logic       lowLevel,
  output logic [1:0] levelCode,
  output logic       levelValid,
  output logic       levelChanged,
  output logic       fault,
  output logic [1:0] stateDebug
);

  localparam int IW = $clog2(FAULT_CYCLES + 1);
  localparam logic [IW-1:0] FAULT_MAX = IW'(FAULT_CYCLES);

  stateT         state;
  stateT         stateNext;
  logic [6:0]    segments;
  logic [6:0]    stableSample;
  logic          stableHit;
  logic          clearReq;
  logic          primed;
  logic          sampleBad;
  logic          trip;
  logic          commit;
  logic [IW-1:0] invalidCount;
  logic [IW-1:0] invalidNext;
  decodeT        sampleDecode;

  assign segments   = {segA, segB, segC, segD, segE, segF, segG};
  assign stateDebug = state;

  segment_stability_filter #(
    .STABLE_CYCLES(STABLE_CYCLES)
  ) u_filter (
    .clock        (clock),
    .reset        (reset),
    .clear        (clearReq),
    .segments     (segments),
    .stableSample (stableSample),
    .stableHit    (stableHit)
  );

  // Decode, invalid-run counting and the state transition decision.
  // The reset value of the sample register is not a real sample, so the
  // invalid counter ignores it until the first post-reset edge (primed).
  always_comb begin
    clearReq     = (state == FAULT) && faultClear;
    sampleDecode = decodePattern(stableSample);
    sampleBad    = primed && !sampleDecode.valid;
    invalidNext  = invalidCount;
    if (clearReq || !sampleBad) begin
      invalidNext = '0;
    end else if (invalidCount != FAULT_MAX) begin
      invalidNext = invalidCount + 1'b1;
    end
    trip   = (state != FAULT) && (invalidNext == FAULT_MAX);
    commit = (state != FAULT) && !trip && stableHit && sampleDecode.valid &&
             ((state == ACQUIRE) || (sampleDecode.code != levelCode));
    stateNext = state;
    case (state)
      ACQUIRE, LOCKED: begin
        if (trip) begin
          stateNext = FAULT;
        end else if (commit) begin
          stateNext = LOCKED;
        end
      end
      FAULT: begin
        if (faultClear) begin
          stateNext = ACQUIRE;
        end
      end
      default: stateNext = ACQUIRE;
    endcase
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state        <= ACQUIRE;
      primed       <= 1'b0;
      invalidCount <= '0;
      levelCode    <= LEVEL_EMPTY;
      highLevel    <= 1'b0;
      mediumLevel  <= 1'b0;
      lowLevel     <= 1'b0;
      levelValid   <= 1'b0;
      levelChanged <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= stateNext;
      primed       <= 1'b1;
      invalidCount <= invalidNext;
      levelChanged <= commit;
      levelValid   <= (stateNext == LOCKED);
      fault        <= (stateNext == FAULT);
      if (commit) begin
        levelCode   <= sampleDecode.code;
        highLevel   <= (sampleDecode.code == LEVEL_FULL);
        mediumLevel <= (sampleDecode.code == LEVEL_FULL) || (sampleDecode.code == LEVEL_MEDIUM);
        lowLevel    <= (sampleDecode.code != LEVEL_EMPTY);
      end
    end
  end

endmodule

// File: tb/tb_decoder_nivel_caixa.sv
// Directed plus randomized bench for decoder_nivel_caixa with a
// history-based reference model.
module tb_decoder_nivel_caixa;

  localparam int S = 4;
  localparam int F = 16;
  localparam int M_ACQ = 0;
  localparam int M_LOCK = 1;
  localparam int M_FAULT = 2;

  // Clock and DUT signals
  logic       clock = 1'b0;
  logic       reset;
  logic       segA, segB, segC, segD, segE, segF, segG;
  logic       faultClear;
  logic       highLevel, mediumLevel, lowLevel;
  logic [1:0] levelCode;
  logic       levelValid, levelChanged, fault;
  logic [1:0] stateDebug;

  always #5 clock = ~clock;

  decoder_nivel_caixa #(
    .STABLE_CYCLES(S),
    .FAULT_CYCLES (F)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .segA         (segA),
    .segB         (segB),
    .segC         (segC),
    .segD         (segD),
    .segE         (segE),
    .segF         (segF),
    .segG         (segG),
    .faultClear   (faultClear),
    .highLevel    (highLevel),
    .mediumLevel  (mediumLevel),
    .lowLevel     (lowLevel),
    .levelCode    (levelCode),
    .levelValid   (levelValid),
    .levelChanged (levelChanged),
    .fault        (fault),
    .stateDebug   (stateDebug)
  );

  // Scoreboard counters
  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  // Reference model state
  logic [6:0] hist[$];      // samples since the last fresh start
  bit         mPrimed;
  logic [6:0] mLastX;
  bit         pendHit;
  logic [6:0] pendSample;
  int         badRun;
  int         mMode;
  logic [1:0] mCode;
  bit         mChanged;

  function automatic bit patValid(input logic [6:0] p);
    return (p == 7'h36) || (p == 7'h76) || (p == 7'h37) || (p == 7'h31);
  endfunction

  function automatic logic [1:0] patCode(input logic [6:0] p);
    case (p)
      7'h36:   return 2'd3;
      7'h76:   return 2'd2;
      7'h37:   return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // One clock edge of the reference model, applied with the inputs seen at that edge.
  task automatic modelEdge(input logic [6:0] x, input logic clr, input logic rst);
    bit clearing;
    bit lastBad;
    int newBad;
    int n;
    bit runOk;
    if (!rst) begin
      hist.delete();
      mPrimed = 0; mLastX = 7'h00; pendHit = 0; pendSample = 7'h00;
      badRun = 0; mMode = M_ACQ; mCode = 2'd0; mChanged = 0;
      return;
    end
    clearing = (mMode == M_FAULT) && clr;
    lastBad  = mPrimed && !patValid(mLastX);
    newBad   = clearing ? 0 : (lastBad ? ((badRun + 1 > F) ? F : badRun + 1) : 0);
    mChanged = 0;
    if (mMode == M_FAULT) begin
      if (clr) mMode = M_ACQ;
    end else if (newBad == F) begin
      mMode = M_FAULT;
    end else if (pendHit && patValid(pendSample) &&
                 ((mMode == M_ACQ) || (patCode(pendSample) != mCode))) begin
      mCode = patCode(pendSample);
      mChanged = 1;
      mMode = M_LOCK;
    end
    badRun = newBad;
    pendSample = x;
    if (clearing) begin
      hist.delete();
      pendHit = 0;
    end else begin
      hist.push_back(x);
      if (hist.size() > S + 1) void'(hist.pop_front());
      n = hist.size();
      runOk = (n >= S);
      for (int i = n - S; runOk && i < n; i++) if (hist[i] != x) runOk = 0;
      if (runOk && n > S && hist[n-S-1] == x) runOk = 0;
      pendHit = runOk;
    end
    mLastX = x;
    mPrimed = 1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checkCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      failCount++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic checkModel();
    check("levelCode",    levelCode,    mCode);
    check("highLevel",    highLevel,    mCode == 2'd3);
    check("mediumLevel",  mediumLevel,  mCode >= 2'd2);
    check("lowLevel",     lowLevel,     mCode >= 2'd1);
    check("levelValid",   levelValid,   mMode == M_LOCK);
    check("levelChanged", levelChanged, mChanged);
    check("fault",        fault,        mMode == M_FAULT);
  endtask

  // Driver: apply inputs away from the edge, advance one edge, compare.
  task automatic step(input logic [6:0] seg, input logic clr, input logic rst);
    {segA, segB, segC, segD, segE, segF, segG} = seg;
    faultClear = clr;
    reset = rst;
    @(posedge clock);
    modelEdge(seg, clr, rst);
    #1;
    checkModel();
  endtask

  task automatic hold(input logic [6:0] seg, input logic clr, input int n);
    for (int i = 0; i < n; i++) step(seg, clr, 1'b1);
  endtask

  initial begin
    logic [6:0] p;
    int len;
    logic [6:0] validTab[4];
    validTab[0] = 7'h36; validTab[1] = 7'h76; validTab[2] = 7'h37; validTab[3] = 7'h31;
    reset = 1'b0; faultClear = 1'b0;
    {segA, segB, segC, segD, segE, segF, segG} = 7'h00;
    #1;

    // Reset values
    step(7'h00, 1'b0, 1'b0);
    step(7'h00, 1'b0, 1'b0);
    check("rst_levelCode", levelCode, 2'd0);
    check("rst_levels", {highLevel, mediumLevel, lowLevel}, 3'b000);
    check("rst_flags", {levelValid, levelChanged, fault}, 3'b000);

    // Medium commits at edge 4 after release
    for (int i = 0; i <= 4; i++) begin
      step(7'h76, 1'b0, 1'b1);
      if (i < 4) check("t1_no_early_pulse", levelChanged, 1'b0);
    end
    check("t1_code", levelCode, 2'd2);
    check("t1_levels", {highLevel, mediumLevel, lowLevel}, 3'b011);
    check("t1_valid", levelValid, 1'b1);
    check("t1_pulse", levelChanged, 1'b1);
    step(7'h76, 1'b0, 1'b1);
    check("t1_pulse_one_cycle", levelChanged, 1'b0);

    // Short full glitch is rejected, long full commits
    for (int i = 0; i < 3; i++) begin
      step(7'h36, 1'b0, 1'b1);
      check("t2_glitch_no_pulse", levelChanged, 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      step(7'h76, 1'b0, 1'b1);
      check("t2_glitch_no_pulse", levelChanged, 1'b0);
      check("t2_hold_medium", levelCode, 2'd2);
    end
    for (int i = 0; i <= 5; i++) begin
      step(7'h36, 1'b0, 1'b1);
      check("t2_full_pulse", levelChanged, (i == 4) ? 1'b1 : 1'b0);
    end
    check("t2_full_code", levelCode, 2'd3);

    // Go to low, then invalid run interrupted by one valid sample
    hold(7'h37, 1'b0, 6);
    check("t3_low_code", levelCode, 2'd1);
    hold(7'h30, 1'b0, 10);
    step(7'h31, 1'b0, 1'b1);
    check("t3_glitch_valid", levelValid, 1'b1);
    for (int i = 0; i <= 16; i++) begin
      step(7'h30, 1'b0, 1'b1);
      if (i == 15) check("t3_no_early_fault", fault, 1'b0);
    end
    check("t3_fault", fault, 1'b1);
    check("t3_valid_low", levelValid, 1'b0);
    check("t3_levels_held", {highLevel, mediumLevel, lowLevel}, 3'b001);

    // Clear fault with empty on the inputs, empty commits from fresh samples
    hold(7'h31, 1'b0, 3);
    check("t4_fault_held", fault, 1'b1);
    step(7'h31, 1'b1, 1'b1);
    check("t4_cleared", {fault, levelValid}, 2'b00);
    for (int i = 1; i <= 5; i++) begin
      step(7'h31, 1'b0, 1'b1);
      check("t4_empty_pulse", levelChanged, (i == 5) ? 1'b1 : 1'b0);
    end
    check("t4_empty_code", levelCode, 2'd0);
    check("t4_valid", levelValid, 1'b1);

    // faultClear held with invalid input: trip, clear, re-count, reset mid-count
    for (int i = 0; i <= 16; i++) step(7'h70, 1'b1, 1'b1);
    check("t5_trip", fault, 1'b1);
    step(7'h70, 1'b1, 1'b1);
    check("t5_clear_ignored_outside", fault, 1'b0);
    hold(7'h70, 1'b1, 8);
    step(7'h70, 1'b1, 1'b0);
    check("t5_rst_code", levelCode, 2'd0);
    check("t5_rst_levels", {highLevel, mediumLevel, lowLevel}, 3'b000);
    check("t5_rst_flags", {levelValid, levelChanged, fault}, 3'b000);

    // Randomized segment runs with occasional clear and reset
    for (int r = 0; r < 70; r++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: p = validTab[$urandom_range(0, 3)];
        5, 6: p = 7'h30;
        7: p = 7'h70;
        default: begin
          p = 7'($urandom_range(0, 127));
          while (patValid(p)) p = 7'($urandom_range(0, 127));
        end
      endcase
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++)
        step(p, ($urandom_range(0, 5) == 0), ($urandom_range(0, 199) != 0));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
